// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master command port between NREQ requesters.
// Optional WAIT-state timeout abort is compiled in with `define APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ*2-1:0]  req_strb,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic [DW-1:0]    rdata,
  output logic             err,
  output logic             m_valid,
  output logic             m_psel,
  output logic             m_write,
  output logic [AW-1:0]    m_addr,
  output logic [DW-1:0]    m_wdata,
  output logic [1:0]       m_strb,
  input  logic             m_pready,
  input  logic [DW-1:0]    m_rdata
);

  localparam int PW = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  generate
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
      $error("apb_req_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end
  endgenerate

  logic [1:0]      state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   cur;
  logic            found;
  logic [PW-1:0]   pick;
  logic [NREQ-1:0] pick_oh;
  int              idx;

  // First requester at or after ptr, wrapping; ptr itself has top priority.
  // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    pick_oh = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found        = 1'b1;
        pick         = PW'(idx);
        pick_oh      = '0;
        pick_oh[idx] = 1'b1;
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: every register, including the latched command fields, has an async reset value.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      cur     <= '0;
      gnt     <= '0;
      done    <= '0;
      rdata   <= '0;
      m_valid <= 1'b0;
      m_psel  <= 1'b0;
      m_write <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_strb  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt     <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      m_valid <= 1'b0;
      done    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (found) begin
            state   <= ST_GRANT;
            cur     <= pick;
            gnt     <= pick_oh;
            m_valid <= 1'b1;
            m_psel  <= 1'b1;
            m_write <= req_write[pick];
            m_addr  <= req_addr[int'(pick)*AW +: AW];
            m_wdata <= req_wdata[int'(pick)*DW +: DW];
            m_strb  <= req_write[pick] ? req_strb[int'(pick)*2 +: 2] : 2'b00;
          end
        end

        ST_GRANT: begin
          state <= ST_WAIT;
`ifdef APB_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end

        ST_WAIT: begin
          if (m_pready) begin
            state <= ST_DONE;
            done  <= gnt;
            rdata <= m_write ? '0 : m_rdata;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            // Abort: complete toward the requester with an error and no data.
            state <= ST_DONE;
            done  <= gnt;
            rdata <= '0;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          gnt    <= '0;
          m_psel <= 1'b0;
          rdata  <= '0;
          ptr    <= (cur == PW'(NREQ - 1)) ? '0 : cur + 1'b1;
        end

        default: begin
          state  <= ST_IDLE;
          gnt    <= '0;
          m_psel <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter that shares one APB master port between NREQ local requesters. Sits between the requesters and the APB master's command interface (valid/psel/write/addr/pwdata/pstrobe in, pready/prdata back), and runs one transfer at a time to completion. Latches the winning request and holds it stable for the whole transfer. Returns read data and a one-cycle completion pulse to the granted requester.

## Interface
- NREQ, 4: number of requesters, 2..8
- AW, 32: address width
- DW, 32: data width
- TIMEOUT, 16: maximum WAIT cycles before abort; used only with the timeout feature
- pclk  in  1  clock; all logic on the rising edge
- presetn  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*AW  flattened; requester i uses bits [i*AW +: AW]
- req_wdata  in  NREQ*DW  flattened write data
- req_strb  in  NREQ*2  flattened write strobe
- gnt  out  NREQ  one-hot grant; high from GRANT through DONE
- done  out  NREQ  one-hot, one-cycle completion pulse
- rdata  out  DW  read data; valid while done is high
- err  out  1  timeout flag; 0 when the timeout feature is compiled out
- m_valid  out  1  one-cycle start pulse to the master
- m_psel, m_write  out  1  latched select (1) and direction
- m_addr  out  AW  latched address
- m_wdata  out  DW  latched write data
- m_strb  out  2  latched strobe; 0 for reads
- m_pready  in  1  transfer-complete from the master/slave
- m_rdata  in  DW  read data from the master

## Operation
- States: IDLE, GRANT, WAIT, DONE. Encoding 2 bits; illegal state goes to IDLE.
- IDLE: if any req is high, pick the first set bit at or after ptr, wrapping modulo NREQ. Latch that requester's write/addr/wdata/strb into the m_* registers and go to GRANT.
- GRANT: gnt[i]=1, m_valid=1 for exactly this cycle. Go to WAIT.
- WAIT: hold all m_* values. When m_pready=1, capture m_rdata into rdata (reads only; writes leave rdata at 0) and go to DONE.
- DONE: done[i]=1 for one cycle, set ptr to (i+1) mod NREQ, then go to IDLE. gnt clears on entry to IDLE.
- Requester contract: hold req and its fields until done. A req deasserted mid-transfer does not abort the transfer; it still completes and done still pulses.
- A req high in IDLE on the cycle after DONE is eligible immediately, so back-to-back grants are possible.

## Timing
- Reset values: gnt=0, done=0, rdata=0, err=0, m_valid=0, m_psel=0, m_write=0, m_addr=0, m_wdata=0, m_strb=0, ptr=0, state=IDLE.
- Cycle n: req sampled in IDLE. Cycle n+1: GRANT, with gnt and m_valid high. Cycles n+2 onward: WAIT.
- If m_pready is sampled high at cycle k, done and rdata are high/valid at k+1 and IDLE is reached at k+2.
- Minimum transfer is 4 cycles from req to IDLE. With continuous requests, the bus carries one transfer per 4+W cycles, where W is the number of extra WAIT cycles.
- m_pready outside WAIT is ignored.
- presetn low at any time forces the reset values asynchronously. An in-flight transfer is dropped with no done pulse.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - Adds a WAIT cycle counter, cleared on entry to WAIT.
  - If the counter reaches TIMEOUT with no m_pready, the block goes to DONE with err=1 and rdata=0. err is high only during that DONE cycle.
  - ptr advances as on a normal completion.
- APB_ARB_TIMEOUT_EN not defined: no counter, err tied to 0, WAIT may last indefinitely.

## Test plan
- Single read: req=4'b0010, req_addr[1]=0x40, m_rdata=0xDEADBEEF with m_pready asserted on the 2nd WAIT cycle -> m_valid pulses once, m_addr=0x40, m_write=0, done=4'b0010 for one cycle, rdata=0xDEADBEEF.
- Single write: req=4'b0001, wdata=0x12345678, strb=2'b11 -> m_wdata=0x12345678, m_strb=2'b11, m_write=1 stable through WAIT; done=4'b0001.
- Round-robin fairness: req=4'b1111 held, m_pready=1 immediately each time -> grants in order 0,1,2,3,0; each gnt is one-hot.
- Wrap and skip: ptr=3, req=4'b0101 -> grant 0 (wrap), then grant 2.
- Reset mid-WAIT: presetn low during WAIT -> all outputs 0 immediately, no done pulse, next request is granted starting from index 0.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT=16): m_pready held low -> done and err high together 16 cycles after entering WAIT, rdata=0.
